// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions.
// Holds the datapath/register-address widths, the ALU select encodings
// (shared with the ALU) and the issue-stage state encoding.
package riscv_pkg;

  localparam int WIDTH = 32;
  localparam int RA_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_sel_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } issue_state_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational forwarding and load-use detection for the issue stage.
// Ports:
//   rs1_addr/rs2_addr, rs1_data/rs2_data : source numbers and register-file data
//   use_pc/use_imm                       : source rs1/rs2 is not used when set
//   ex_we/ex_rd/ex_data/ex_is_load       : instruction in the EX stage
//   mem_we/mem_rd/mem_data               : instruction in the MEM stage
//   rs1_sel/rs2_sel                      : forwarded source values
//   luh                                  : load-use hazard on a used source
module hazard_unit
  import riscv_pkg::*;
(
  input  logic [RA_W-1:0]  rs1_addr,
  input  logic [RA_W-1:0]  rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             use_pc,
  input  logic             use_imm,
  input  logic             ex_we,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic [WIDTH-1:0] ex_data,
  input  logic             ex_is_load,
  input  logic             mem_we,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] rs1_sel,
  output logic [WIDTH-1:0] rs2_sel,
  output logic             luh
);

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;

  // x0 is hardwired to zero, so a write to it never forwards.
  assign ex_hit1  = ex_we  && (ex_rd  != '0) && (ex_rd  == rs1_addr);
  assign ex_hit2  = ex_we  && (ex_rd  != '0) && (ex_rd  == rs2_addr);
  assign mem_hit1 = mem_we && (mem_rd != '0) && (mem_rd == rs1_addr);
  assign mem_hit2 = mem_we && (mem_rd != '0) && (mem_rd == rs2_addr);

  // EX is the younger producer, so it wins over MEM.
  assign rs1_sel = ex_hit1 ? ex_data : (mem_hit1 ? mem_data : rs1_data);
  assign rs2_sel = ex_hit2 ? ex_data : (mem_hit2 ? mem_data : rs2_data);

  // A load in EX has no data yet; stall only if the matching source is used.
  assign luh = ex_is_load && ((ex_hit1 && !use_pc) || (ex_hit2 && !use_imm));

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register of the RV32 core, directly upstream of the ALU.
// Accepts decoded instructions over valid/ready, resolves EX/MEM operand
// forwarding, inserts load-use bubbles and counts them (saturating).
// Ports:
//   clk, rst_n (async active-low)
//   in_*       : decoded instruction and its valid/ready handshake
//   fwd_ex_*   : EX-stage destination/data/load flag
//   fwd_mem_*  : MEM-stage destination/data
//   flush      : synchronous squash (highest priority)
//   out_valid/out_ready, alu_in_a/alu_in_b/alu_select, out_rd_addr/out_rd_we
//   bubble_cnt : saturating count of inserted load-use bubbles
module alu_issue_stage
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RA_W-1:0]  in_rs1_addr,
  input  logic [RA_W-1:0]  in_rs2_addr,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             in_use_imm,
  input  logic             in_use_pc,
  input  logic [3:0]       in_alu_select,
  input  logic [RA_W-1:0]  in_rd_addr,
  input  logic             in_rd_we,
  input  logic             fwd_ex_we,
  input  logic [RA_W-1:0]  fwd_ex_rd,
  input  logic [WIDTH-1:0] fwd_ex_data,
  input  logic             fwd_ex_is_load,
  input  logic             fwd_mem_we,
  input  logic [RA_W-1:0]  fwd_mem_rd,
  input  logic [WIDTH-1:0] fwd_mem_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_select,
  output logic [RA_W-1:0]  out_rd_addr,
  output logic             out_rd_we,
  output logic [31:0]      bubble_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [WIDTH-1:0] rs1_sel_p0, rs2_sel_p0;
  logic             luh_p0, adv_p0;

  hazard_unit u_hazard (
    .rs1_addr   (in_rs1_addr),
    .rs2_addr   (in_rs2_addr),
    .rs1_data   (in_rs1_data),
    .rs2_data   (in_rs2_data),
    .use_pc     (in_use_pc),
    .use_imm    (in_use_imm),
    .ex_we      (fwd_ex_we),
    .ex_rd      (fwd_ex_rd),
    .ex_data    (fwd_ex_data),
    .ex_is_load (fwd_ex_is_load),
    .mem_we     (fwd_mem_we),
    .mem_rd     (fwd_mem_rd),
    .mem_data   (fwd_mem_data),
    .rs1_sel    (rs1_sel_p0),
    .rs2_sel    (rs2_sel_p0),
    .luh        (luh_p0)
  );

  issue_state_t     state_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic [3:0]       sel_p1;
  logic [RA_W-1:0]  rd_p1;
  logic             rd_we_p1;
  logic [31:0]      cnt_p1;

  assign adv_p0   = !vld_p1 || out_ready;
  assign in_ready = adv_p0 && !luh_p0 && !flush;

  // ---- p0 -> p1: issue register (ID/EX boundary) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      vld_p1   <= 1'b0;
      a_p1     <= '0;
      b_p1     <= '0;
      sel_p1   <= '0;
      rd_p1    <= '0;
      rd_we_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else if (flush) begin
      state_p1 <= EMPTY;
      vld_p1   <= 1'b0;
      rd_we_p1 <= 1'b0;
    end else if (adv_p0) begin
      if (in_valid && !luh_p0) begin
        state_p1 <= FULL;
        vld_p1   <= 1'b1;
        a_p1     <= in_use_pc  ? in_pc  : rs1_sel_p0;
        b_p1     <= in_use_imm ? in_imm : rs2_sel_p0;
        sel_p1   <= in_alu_select;
        rd_p1    <= in_rd_addr;
        rd_we_p1 <= in_rd_we;
      end else if (in_valid) begin
        // Load-use: hold a bubble; the instruction waits at the input and
        // picks up the load result from the MEM forward next cycle.
        state_p1 <= BUBBLE;
        vld_p1   <= 1'b0;
        rd_we_p1 <= 1'b0;
        cnt_p1   <= sat_inc(cnt_p1);
      end else begin
        state_p1 <= EMPTY;
        vld_p1   <= 1'b0;
        rd_we_p1 <= 1'b0;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign alu_in_a    = a_p1;
  assign alu_in_b    = b_p1;
  assign alu_select  = sel_p1;
  assign out_rd_addr = rd_p1;
  assign out_rd_we   = rd_we_p1;
  assign bubble_cnt  = cnt_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
  import riscv_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [RA_W-1:0]  in_rs1_addr, in_rs2_addr;
  logic [WIDTH-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic             in_use_imm, in_use_pc;
  logic [3:0]       in_alu_select;
  logic [RA_W-1:0]  in_rd_addr;
  logic             in_rd_we;
  logic             fwd_ex_we, fwd_ex_is_load, fwd_mem_we;
  logic [RA_W-1:0]  fwd_ex_rd, fwd_mem_rd;
  logic [WIDTH-1:0] fwd_ex_data, fwd_mem_data;
  logic             flush, out_valid, out_ready;
  logic [WIDTH-1:0] alu_in_a, alu_in_b;
  logic [3:0]       alu_select;
  logic [RA_W-1:0]  out_rd_addr;
  logic             out_rd_we;
  logic [31:0]      bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
    .in_alu_select(in_alu_select),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [RA_W-1:0] rs1, input logic [WIDTH-1:0] d1,
                           input logic [RA_W-1:0] rs2, input logic [WIDTH-1:0] d2,
                           input logic ui, input logic [WIDTH-1:0] imm,
                           input logic up, input logic [WIDTH-1:0] pc,
                           input logic [3:0] sel, input logic [RA_W-1:0] rd);
    in_valid = 1'b1;
    in_rs1_addr = rs1; in_rs1_data = d1;
    in_rs2_addr = rs2; in_rs2_data = d2;
    in_use_imm = ui; in_imm = imm;
    in_use_pc = up; in_pc = pc;
    in_alu_select = sel; in_rd_addr = rd; in_rd_we = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_pc = '0; in_use_imm = 1'b0; in_use_pc = 1'b0;
    in_alu_select = '0; in_rd_addr = '0; in_rd_we = 1'b0;
    fwd_ex_we = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0; fwd_ex_is_load = 1'b0;
    fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt", bubble_cnt, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Forwarding: EX beats MEM on the same register
    set_instr(5'd5, 32'h11, 5'd0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0, ALU_SUB, 5'd3);
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd5; fwd_ex_data = 32'hAA;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hBB;
    tick();
    chk("fwd_ex_valid", {31'd0, out_valid}, 32'd1);
    chk("fwd_ex_a", alu_in_a, 32'hAA);
    chk("fwd_ex_b_imm", alu_in_b, 32'h4);
    chk("fwd_sel", {28'd0, alu_select}, 32'h1);
    chk("fwd_rd", {27'd0, out_rd_addr}, 32'd3);
    chk("fwd_rd_we", {31'd0, out_rd_we}, 32'd1);

    // x0 never forwards
    set_instr(5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0, ALU_ADD, 5'd3);
    fwd_ex_rd = 5'd0; fwd_mem_rd = 5'd0;
    tick();
    chk("x0_no_fwd_a", alu_in_a, 32'h0);

    // MEM forward on rs1, register-file data on rs2
    set_instr(5'd6, 32'h66, 5'd9, 32'h99, 1'b0, 32'h0, 1'b0, 32'h0, ALU_OR, 5'd4);
    fwd_ex_rd = 5'd5; fwd_mem_rd = 5'd6;
    tick();
    chk("mem_fwd_a", alu_in_a, 32'hBB);
    chk("rf_b", alu_in_b, 32'h99);

    // PC operand overrides a matching forward
    set_instr(5'd5, 32'h55, 5'd9, 32'h99, 1'b0, 32'h0, 1'b1, 32'h100, ALU_ADD, 5'd4);
    tick();
    chk("pc_a", alu_in_a, 32'h100);

    // Load-use on rs2
    set_instr(5'd0, 32'h0, 5'd7, 32'h5, 1'b0, 32'h0, 1'b0, 32'h0, ALU_XOR, 5'd8);
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd7; fwd_ex_data = 32'hDEAD; fwd_ex_is_load = 1'b1;
    fwd_mem_we = 1'b0;
    #1;
    chk("luh_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("luh_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("luh_bubble_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("luh_cnt", bubble_cnt, 32'd1);
    fwd_ex_we = 1'b0; fwd_ex_is_load = 1'b0; fwd_ex_rd = 5'd0;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd7; fwd_mem_data = 32'h1234;
    #1;
    chk("luh_after_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("luh_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("luh_mem_b", alu_in_b, 32'h1234);
    chk("luh_cnt_hold", bubble_cnt, 32'd1);

    // Backpressure: hold 3 cycles while forwards change
    out_ready = 1'b0;
    set_instr(5'd2, 32'h77, 5'd0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0, ALU_AND, 5'd10);
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd7; fwd_ex_data = 32'hFFFF; fwd_mem_data = 32'h4321;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_b_hold", alu_in_b, 32'h1234);
      chk("bp_rd_hold", {27'd0, out_rd_addr}, 32'd8);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_a", alu_in_a, 32'h77);
    chk("bp_next_b", alu_in_b, 32'h8);
    chk("bp_next_rd", {27'd0, out_rd_addr}, 32'd10);

    // Flush with valid input and valid output
    set_instr(5'd2, 32'h77, 5'd0, 32'h0, 1'b1, 32'h55, 1'b0, 32'h0, ALU_ADD, 5'd11);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("flush_no_capture", alu_in_b, 32'h8);

    // Flush during a load-use hazard does not count a bubble
    set_instr(5'd7, 32'h0, 5'd0, 32'h0, 1'b1, 32'h1, 1'b0, 32'h0, ALU_ADD, 5'd1);
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd7; fwd_ex_is_load = 1'b1;
    tick();
    chk("flush_luh_cnt", bubble_cnt, 32'd1);
    flush = 1'b0;

    // Counter saturation
    force dut.cnt_p1 = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_p1;
    #1;
    chk("sat_preload", bubble_cnt, 32'hFFFF_FFFE);
    tick();
    chk("sat_reach_max", bubble_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_hold_max", bubble_cnt, 32'hFFFF_FFFF);

    // Async reset mid-FULL
    fwd_ex_we = 1'b0; fwd_ex_is_load = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_a", alu_in_a, 32'd0);
    chk("arst_b", alu_in_b, 32'd0);
    chk("arst_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("arst_cnt", bubble_cnt, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue stage directly upstream of the `ALU`. It accepts decoded instructions over a valid/ready handshake and resolves operand forwarding from the two downstream stages. It inserts load-use bubbles and registers the selected `in_a`/`in_b`/`alu_select` so the combinational `ALU` sees stable operands for one full cycle. It acts as the ID/EX pipeline register of the RV32 core and counts inserted bubbles.

## Interface
- `WIDTH`, 32: datapath width.
- `RA_W`, 5: register-address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_rs1_addr`, `in_rs2_addr` in RA_W: source register numbers.
- `in_rs1_data`, `in_rs2_data` in WIDTH: register-file read data, possibly stale.
- `in_imm`, `in_pc` in WIDTH: immediate and instruction address.
- `in_use_imm` in 1: operand B is `in_imm`, so rs2 is unused.
- `in_use_pc` in 1: operand A is `in_pc`, so rs1 is unused.
- `in_alu_select` in 4: ALU opcode, passed through.
- `in_rd_addr` in RA_W, `in_rd_we` in 1: destination register and write enable.
- `fwd_ex_we` in 1, `fwd_ex_rd` in RA_W, `fwd_ex_data` in WIDTH: the instruction currently in the ALU/EX stage.
- `fwd_ex_is_load` in 1: the EX-stage instruction is a load, so its data is not yet valid.
- `fwd_mem_we` in 1, `fwd_mem_rd` in RA_W, `fwd_mem_data` in WIDTH: the instruction in the MEM stage.
- `flush` in 1: synchronous squash, for example a taken branch.
- `out_valid` out 1, `out_ready` in 1: handshake toward EX.
- `alu_in_a`, `alu_in_b` out WIDTH; `alu_select` out 4: drive the ALU.
- `out_rd_addr` out RA_W, `out_rd_we` out 1: destination passed along.
- `bubble_cnt` out 32: count of inserted load-use bubbles, saturating.

## Operation
- **States:**
  - `EMPTY`: no valid instruction held.
  - `FULL`: `out_valid=1`.
  - `BUBBLE`: a load-use bubble is held, `out_valid=0`.
- **Advance condition:** `adv = !out_valid || out_ready`.
- **Load-use hazard (`luh`):** `fwd_ex_is_load && fwd_ex_we && fwd_ex_rd!=0` and the EX destination matches a used source. rs1 is used iff `!in_use_pc`; rs2 is used iff `!in_use_imm`.
- **Ready:** `in_ready = adv && !luh && !flush`. This path is combinational.
- **Capture:** on `in_valid && in_ready`, register the operands and go to `FULL`.
  - Operand selection per used source, in priority order:
    - EX forward when `fwd_ex_we`, rd matches and rd≠0;
    - else MEM forward under the same rule;
    - else the register-file data.
  - Register x0 is never forwarded.
  - `alu_in_a = in_use_pc ? in_pc : rs1_sel`.
  - `alu_in_b = in_use_imm ? in_imm : rs2_sel`.
- **Load-use bubble:** on `in_valid && adv && luh && !flush`, enter `BUBBLE`.
  - Clear `out_valid` and `out_rd_we`.
  - Increment `bubble_cnt`, saturating at 0xFFFFFFFF.
  - The instruction stays at the input. Next cycle the load is in MEM and the MEM forward supplies the data.
- **Idle:** on `adv && !in_valid`, go to `EMPTY`, `out_valid=0`.
- **Hold:** on `!adv`, all outputs hold exactly, even if forward inputs change.
- **Flush:** `flush` has top priority.
  - Next edge: `out_valid=0`, `out_rd_we=0`, state `EMPTY`, no capture.
  - `bubble_cnt` is unchanged.
- **Arithmetic:** none beyond the saturating counter. The opcode is passed unmodified.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput is 1 per cycle when there is no hazard.
- Load-use costs exactly 1 bubble cycle, then the instruction is accepted.
- **Reset (async, any time, including mid-handshake):**
  - All outputs go to 0 and the state goes to `EMPTY`.
  - `bubble_cnt` goes to 0.
  - `in_ready` reflects the combinational rule after reset (1 when `in_valid` has no hazard).
- `out_valid` and the payload change only on a rising edge where `adv || flush` holds.
- Same-cycle EX and MEM match on the same register: EX wins.
- `flush` in the same cycle as `in_valid`: the input is not accepted and the upstream must re-present or drop it.

## Structure
- Shared package `riscv_pkg`:
  - `WIDTH`, `RA_W`;
  - ALU select encodings (`ALU_ADD`=4'h0, `ALU_SUB`=4'h1, …), shared with `ALU`;
  - the issue-state encoding (`EMPTY`, `FULL`, `BUBBLE`).
- One combinational sub-module `hazard_unit`: forward selection for rs1/rs2 plus `luh` detection.
- The top level holds the FSM, the registers and the counter.

## Test plan
1. Reset mid-`FULL`: assert `rst_n=0` asynchronously. Outputs are 0 immediately; `bubble_cnt`=0.
2. Forwarding:
   - rs1=5, rf=0x11, EX writes x5=0xAA, MEM writes x5=0xBB, `in_use_imm=1` with imm=0x4 → `alu_in_a`=0xAA, `alu_in_b`=0x4.
   - Repeat with rs1=0 → `alu_in_a`=0x0, no forwarding.
3. Load-use: EX is a load to x7; the input uses rs2=7 → `in_ready=0`, one bubble, `bubble_cnt`=1. Next cycle the MEM forward of 0x1234 gives `alu_in_b`=0x1234.
4. Backpressure: `out_ready=0` for 3 cycles while `FULL` → outputs are stable and `in_ready=0`. Release → the next instruction is accepted on the same edge the current one drains.
5. Flush with `in_valid=1` and `out_valid=1` → the next edge gives `out_valid=0` and the input is not accepted.
6. Saturation: preload the counter near max, for example by forcing, so it reaches 0xFFFFFFFF → a further bubble leaves it at 0xFFFFFFFF.
